dm_port_arbiter: RTL and testbench

//  Shares the single data RAM (5-bit one-hot ctrl, 7-bit byte addr, 32-bit wdata/rdata) between two requesters: CPU load/store path and debug/DMA port.

---
 rtl/dm_port_arbiter_pkg.sv | 33 +++
 rtl/dm_rr_pick.sv | 21 ++
 rtl/dm_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_dm_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_port_arbiter_pkg.sv
// Shared definitions for the data-RAM port arbiter: ctrl bit positions, FSM states,
// requester IDs and ctrl decode helpers.
package dm_port_arbiter_pkg;

   localparam int unsigned CTL_W   = 5;
   localparam int unsigned CTL_SW  = 4;
   localparam int unsigned CTL_LW  = 3;
   localparam int unsigned CTL_LB  = 2;
   localparam int unsigned CTL_LBU = 1;
   localparam int unsigned CTL_SB  = 0;

   localparam logic [CTL_W-1:0] CTL_OP_SW = CTL_W'(1) << CTL_SW;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_ISSUE = 2'd2
   } dm_state_t;

   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_DBG = 1'b1
   } dm_port_t;

   function automatic logic ctl_onehot(input logic [CTL_W-1:0] c);
      return (c != '0) && ((c & (c - CTL_W'(1))) == '0);
   endfunction

   function automatic logic ctl_is_load(input logic [CTL_W-1:0] c);
      return ctl_onehot(c) && (c[CTL_LW] || c[CTL_LB] || c[CTL_LBU]);
   endfunction

endpackage

// File: rtl/dm_rr_pick.sv
// Two-way round-robin picker: a lone requester wins; on a tie the port not served last wins.
module dm_rr_pick
   import dm_port_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  dm_port_t   last,
   output dm_port_t   gnt_sel,
   output logic       valid
);

   always_comb begin
      valid   = |req;
      gnt_sel = PORT_CPU;
      if (req == 2'b11) begin
         gnt_sel = (last == PORT_CPU) ? PORT_DBG : PORT_CPU;
      end else if (req[PORT_DBG]) begin
         gnt_sel = PORT_DBG;
      end
   end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares one data RAM between the CPU load/store path and the debug/DMA port,
// with registered grant/read return and an optional post-reset clear of every word.
module dm_port_arbiter
   import dm_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = 7,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned WORDS      = 32,
   parameter bit          INIT_CLEAR = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic [CTL_W-1:0]  cpu_ctrl,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic [CTL_W-1:0]  dbg_ctrl,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              busy,
   output logic [CTL_W-1:0]  dm_ctrl,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   input  logic [DATA_W-1:0] dm_rdata
);

   localparam int unsigned      IDX_W    = ADDR_W - 2;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

   dm_state_t         state;
   dm_state_t         state_next;
   logic [IDX_W-1:0]  idx;
   dm_port_t          last_port;
   dm_port_t          pick_sel;
   dm_port_t          op_port;
   logic              pick_valid;
   logic              grant;
   logic [CTL_W-1:0]  op_ctrl;
   logic [ADDR_W-1:0] op_addr;
   logic [DATA_W-1:0] op_wdata;
   logic [CTL_W-1:0]  sel_ctrl;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   dm_rr_pick u_pick (
      .req     ({dbg_req, cpu_req}),
      .last    (last_port),
      .gnt_sel (pick_sel),
      .valid   (pick_valid)
   );

   always_comb begin
      sel_ctrl  = cpu_ctrl;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
      if (pick_sel == PORT_DBG) begin
         sel_ctrl  = dbg_ctrl;
         sel_addr  = dbg_addr;
         sel_wdata = dbg_wdata;
      end
   end

   always_comb begin
      state_next = state;
      grant      = 1'b0;
      case (state)
         ST_INIT: begin
            if (idx == IDX_LAST) state_next = ST_IDLE;
         end
         ST_IDLE: begin
            if (pick_valid) begin
               grant      = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // RAM pins are quiet while rst is high so an aborted store never commits.
   always_comb begin
      dm_ctrl  = '0;
      dm_addr  = '0;
      dm_wdata = '0;
      if (!rst) begin
         case (state)
            ST_INIT: begin
               dm_ctrl = CTL_OP_SW;
               dm_addr = {idx, 2'b00};
            end
            ST_ISSUE: begin
               dm_ctrl  = op_ctrl;
               dm_addr  = op_addr;
               dm_wdata = op_wdata;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == ST_INIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= INIT_CLEAR ? ST_INIT : ST_IDLE;
         idx        <= '0;
         last_port  <= PORT_DBG;
         op_port    <= PORT_CPU;
         op_ctrl    <= '0;
         op_addr    <= '0;
         op_wdata   <= '0;
         cpu_gnt    <= 1'b0;
         dbg_gnt    <= 1'b0;
         cpu_rvalid <= 1'b0;
         dbg_rvalid <= 1'b0;
         cpu_rdata  <= '0;
         dbg_rdata  <= '0;
      end else begin
         state      <= state_next;
         cpu_gnt    <= grant && (pick_sel == PORT_CPU);
         dbg_gnt    <= grant && (pick_sel == PORT_DBG);
         cpu_rvalid <= 1'b0;
         dbg_rvalid <= 1'b0;
         if (state == ST_INIT) begin
            idx <= idx + IDX_W'(1);
         end
         // Malformed ctrl is still granted but latched as a no-op.
         if (grant) begin
            last_port <= pick_sel;
            op_port   <= pick_sel;
            op_ctrl   <= ctl_onehot(sel_ctrl) ? sel_ctrl : '0;
            op_addr   <= sel_addr;
            op_wdata  <= sel_wdata;
         end
         if ((state == ST_ISSUE) && ctl_is_load(op_ctrl)) begin
            if (op_port == PORT_CPU) begin
               cpu_rdata  <= dm_rdata;
               cpu_rvalid <= 1'b1;
            end else begin
               dbg_rdata  <= dm_rdata;
               dbg_rvalid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter with a behavioural RAM (byte lanes, lb/lbu extension).
module tb_dm_port_arbiter;

   localparam int unsigned AW = 7;
   localparam int unsigned DW = 32;
   localparam int unsigned NW = 32;

   localparam logic [4:0] OP_SW  = 5'b10000;
   localparam logic [4:0] OP_LW  = 5'b01000;
   localparam logic [4:0] OP_LB  = 5'b00100;
   localparam logic [4:0] OP_LBU = 5'b00010;
   localparam logic [4:0] OP_SB  = 5'b00001;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cpu_req = 1'b0, dbg_req = 1'b0;
   logic [4:0]    cpu_ctrl = '0, dbg_ctrl = '0;
   logic [AW-1:0] cpu_addr = '0, dbg_addr = '0;
   logic [DW-1:0] cpu_wdata = '0, dbg_wdata = '0;
   logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, busy;
   logic [DW-1:0] cpu_rdata, dbg_rdata;
   logic [4:0]    dm_ctrl;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [DW-1:0] dm_rdata;

   always #5 clk = ~clk;

   dm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WORDS(NW), .INIT_CLEAR(1'b1)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_ctrl(cpu_ctrl), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_ctrl(dbg_ctrl), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .busy(busy), .dm_ctrl(dm_ctrl), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata)
   );

   // RAM model, preloaded with non-zero junk so the clear sequence is observable.
   logic [DW-1:0] mem [NW];
   logic [DW-1:0] ram_word;
   logic [7:0]    ram_byte;
   bit            preloaded = 1'b0;
   bit            abort_write_seen = 1'b0;

   always_comb begin
      ram_word = mem[dm_addr[AW-1:2]];
      ram_byte = ram_word[8*dm_addr[1:0] +: 8];
      dm_rdata = '0;
      if (dm_ctrl == OP_LW)       dm_rdata = ram_word;
      else if (dm_ctrl == OP_LB)  dm_rdata = {{24{ram_byte[7]}}, ram_byte};
      else if (dm_ctrl == OP_LBU) dm_rdata = {24'h0, ram_byte};
   end

   always @(posedge clk) begin
      if (!preloaded) begin
         for (int i = 0; i < NW; i++) mem[i] <= 32'hA5A5_0000 + i;
         preloaded <= 1'b1;
      end else if (dm_ctrl == OP_SW) begin
         mem[dm_addr[AW-1:2]] <= dm_wdata;
      end else if (dm_ctrl == OP_SB) begin
         mem[dm_addr[AW-1:2]][8*dm_addr[1:0] +: 8] <= dm_wdata[7:0];
      end
      if ((dm_ctrl == OP_SW || dm_ctrl == OP_SB) && dm_wdata == 32'h55AA_55AA)
         abort_write_seen <= 1'b1;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      bit          rv;
      int          cyc;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic [4:0]    ctrl;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } op_t;

   exp_t cpu_exp[$];
   exp_t dbg_exp[$];
   op_t  cpu_ops[$];
   op_t  dbg_ops[$];

   task automatic expect_ev(input bit p, input bit rv, input int c, input logic [31:0] d);
      exp_t e;
      e.rv = rv; e.cyc = c; e.data = d;
      if (p) dbg_exp.push_back(e);
      else   cpu_exp.push_back(e);
   endtask

   task automatic sb_check(input bit p, input bit rv, input logic [31:0] data);
      exp_t e;
      n_cmp++;
      if ((p ? dbg_exp.size() : cpu_exp.size()) == 0) begin
         n_bad++;
         $display("FAIL unexpected %s on port %0d: got event at cycle %0d, required none",
                  rv ? "rvalid" : "gnt", p, cyc);
         return;
      end
      e = p ? dbg_exp.pop_front() : cpu_exp.pop_front();
      if (e.rv != rv || e.cyc != cyc || (rv && data !== e.data)) begin
         n_bad++;
         $display("FAIL sb port %0d: got %s cyc %0d data %h, required %s cyc %0d data %h",
                  p, rv ? "rvalid" : "gnt", cyc, data, e.rv ? "rvalid" : "gnt", e.cyc, e.data);
      end
   endtask

   bit watch_ctrl = 1'b0;
   int ctrl_nonzero = 0;

   always @(negedge clk) begin
      if (cpu_gnt)    sb_check(1'b0, 1'b0, cpu_rdata);
      if (cpu_rvalid) sb_check(1'b0, 1'b1, cpu_rdata);
      if (dbg_gnt)    sb_check(1'b1, 1'b0, dbg_rdata);
      if (dbg_rvalid) sb_check(1'b1, 1'b1, dbg_rdata);
      if (watch_ctrl && dm_ctrl != '0) ctrl_nonzero++;
   end

   task automatic drive(input bit p, input bit req, input op_t o);
      if (p) begin
         dbg_req = req; dbg_ctrl = o.ctrl; dbg_addr = o.addr; dbg_wdata = o.wdata;
      end else begin
         cpu_req = req; cpu_ctrl = o.ctrl; cpu_addr = o.addr; cpu_wdata = o.wdata;
      end
   endtask

   // Keeps req high, swapping to the next queued op on each grant, drops after the last.
   task automatic requester(input bit p, input int n);
      op_t o;
      int  got = 0;
      o = p ? dbg_ops.pop_front() : cpu_ops.pop_front();
      drive(p, 1'b1, o);
      for (int t = 0; t < 40 && got < n; t++) begin
         @(negedge clk);
         if (p ? dbg_gnt : cpu_gnt) begin
            got++;
            if (got < n) begin
               o = p ? dbg_ops.pop_front() : cpu_ops.pop_front();
               drive(p, 1'b1, o);
            end else begin
               drive(p, 1'b0, o);
            end
         end
      end
      n_cmp++;
      if (got < n) begin
         n_bad++;
         $display("FAIL grant timeout port %0d: got %0d grants, required %0d", p, got, n);
         drive(p, 1'b0, o);
      end
   endtask

   task automatic single(input bit p, input logic [4:0] c, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input bit ld, input logic [31:0] ed);
      int  k;
      op_t o;
      @(posedge clk); #1;
      k = cyc;
      expect_ev(p, 1'b0, k + 1, '0);
      if (ld) expect_ev(p, 1'b1, k + 2, ed);
      o.ctrl = c; o.addr = a; o.wdata = wd;
      if (p) dbg_ops.push_back(o);
      else   cpu_ops.push_back(o);
      requester(p, 1);
      repeat (2) @(posedge clk);
   endtask

   task automatic check_init();
      for (int i = 0; i < NW; i++) begin
         @(negedge clk);
         chk("init busy", 32'(busy), 32'd1);
         chk("init ctrl", 32'(dm_ctrl), 32'(OP_SW));
         chk("init addr", 32'(dm_addr), 32'(i * 4));
         chk("init wdata", dm_wdata, 32'h0);
      end
      @(negedge clk);
      chk("init end busy", 32'(busy), 32'd0);
      chk("idle ctrl", 32'(dm_ctrl), 32'd0);
   endtask

   task automatic put_op(input bit p, input logic [4:0] c, input logic [AW-1:0] a);
      op_t o;
      o.ctrl = c; o.addr = a; o.wdata = '0;
      if (p) dbg_ops.push_back(o);
      else   cpu_ops.push_back(o);
   endtask

   initial begin
      #100000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int  k;
      bit  found;
      bit  gseen;
      op_t o;

      repeat (2) @(posedge clk);
      #1;
      chk("rst busy", 32'(busy), 32'd1);
      chk("rst dm_ctrl", 32'(dm_ctrl), 32'd0);
      chk("rst gnts", 32'({cpu_gnt, dbg_gnt}), 32'd0);
      chk("rst rvalids", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
      chk("rst cpu_rdata", cpu_rdata, 32'h0);
      chk("rst dbg_rdata", dbg_rdata, 32'h0);
      rst = 1'b0;
      check_init();

      for (int i = 0; i < NW; i++) single(1'b1, OP_LW, AW'(i * 4), '0, 1'b1, 32'h0);

      single(1'b0, OP_SW, 7'h08, 32'hDEAD_BEEF, 1'b0, '0);
      single(1'b0, OP_LW, 7'h08, '0, 1'b1, 32'hDEAD_BEEF);
      single(1'b1, OP_SW, 7'h0C, 32'hCAFE_F00D, 1'b0, '0);

      // Both ports request every cycle; last winner was DBG so CPU goes first.
      @(posedge clk); #1;
      k = cyc;
      put_op(1'b0, OP_LW, 7'h08);
      put_op(1'b0, OP_LW, 7'h0C);
      put_op(1'b1, OP_LW, 7'h0C);
      put_op(1'b1, OP_LW, 7'h08);
      expect_ev(1'b0, 1'b0, k + 1, '0);
      expect_ev(1'b0, 1'b1, k + 2, 32'hDEAD_BEEF);
      expect_ev(1'b0, 1'b0, k + 5, '0);
      expect_ev(1'b0, 1'b1, k + 6, 32'hCAFE_F00D);
      expect_ev(1'b1, 1'b0, k + 3, '0);
      expect_ev(1'b1, 1'b1, k + 4, 32'hCAFE_F00D);
      expect_ev(1'b1, 1'b0, k + 7, '0);
      expect_ev(1'b1, 1'b1, k + 8, 32'hDEAD_BEEF);
      fork
         requester(1'b0, 2);
         requester(1'b1, 2);
      join
      repeat (3) @(posedge clk);
      #1;
      chk("alt cpu_rdata hold", cpu_rdata, 32'hCAFE_F00D);
      chk("alt dbg_rdata hold", dbg_rdata, 32'hDEAD_BEEF);

      single(1'b1, OP_SW, 7'h08, 32'h0, 1'b0, '0);
      single(1'b1, OP_SB, 7'h0B, 32'h0000_0080, 1'b0, '0);
      single(1'b0, OP_LB, 7'h0B, '0, 1'b1, 32'hFFFF_FF80);
      single(1'b0, OP_LBU, 7'h0B, '0, 1'b1, 32'h0000_0080);

      watch_ctrl = 1'b1;
      single(1'b0, 5'b11000, 7'h08, 32'h1234_5678, 1'b0, '0);
      watch_ctrl = 1'b0;
      chk("bad ctrl dm_ctrl cycles", 32'(ctrl_nonzero), 32'd0);
      single(1'b0, OP_LW, 7'h08, '0, 1'b1, 32'h8000_0000);

      // Reset in the middle of the clear sequence.
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (dm_addr == 7'h28) found = 1'b1;
      end
      chk("mid-init idx10 reached", 32'(found), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check_init();

      // Reset during the ISSUE cycle of a store.
      @(posedge clk); #1;
      k = cyc;
      expect_ev(1'b0, 1'b0, k + 1, '0);
      o.ctrl = OP_SW; o.addr = 7'h10; o.wdata = 32'h55AA_55AA;
      drive(1'b0, 1'b1, o);
      gseen = 1'b0;
      for (int t = 0; t < 10 && !gseen; t++) begin
         @(negedge clk);
         if (cpu_gnt) gseen = 1'b1;
      end
      chk("mid-issue gnt seen", 32'(gseen), 32'd1);
      rst = 1'b1;
      drive(1'b0, 1'b0, o);
      @(posedge clk); #1 rst = 1'b0;
      check_init();
      chk("aborted sw not committed", 32'(abort_write_seen), 32'd0);
      chk("post-abort cpu_rdata", cpu_rdata, 32'h0);
      repeat (2) @(posedge clk);

      chk("cpu expectations left", 32'(cpu_exp.size()), 32'd0);
      chk("dbg expectations left", 32'(dbg_exp.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
